param_updown_counter: RTL and testbench

- Parametrised up/down counter for general timing and event counting. It is the next generation of the fixed 4-bit up-counter.
- Adds configurable width and modulus, direction control, synchronous load and clear, and wrap or saturate mode.
- Adds an enable-gated prescaler, a terminal-count pulse and sticky overflow/underflow flags.
- Sits beside control FSMs as a tick, timeout or event counter.

---
 rtl/param_updown_counter_pkg.sv | 24 ++
 rtl/param_updown_counter_if.sv | 28 ++
 rtl/param_updown_counter_prescale_tick.sv | 46 ++++
 rtl/param_updown_counter.sv | 98 +++++++++
 tb/tb_param_updown_counter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/param_updown_counter_pkg.sv
// Shared types and helpers for the parametrised up/down counter.
// Boundary-mode and direction encodings plus the load clamp used by the top level.
package param_updown_counter_pkg;

  localparam int unsigned CNT_MAX_W = 32;

  typedef logic [CNT_MAX_W-1:0] cnt_word_t;

  typedef enum logic {
    CNT_MODE_WRAP = 1'b0,
    CNT_MODE_SAT  = 1'b1
  } cnt_mode_e;

  typedef enum logic {
    CNT_DIR_DOWN = 1'b0,
    CNT_DIR_UP   = 1'b1
  } cnt_dir_e;

  // Limits a requested load value to the legal count range 0..max_value.
  function automatic cnt_word_t clamp_load(input cnt_word_t value, input cnt_word_t max_value);
    return (value > max_value) ? max_value : value;
  endfunction

endpackage

// File: rtl/param_updown_counter_if.sv
// Control and status bundle of the up/down counter.
// The master drives the controls and observes the count; the counter is the slave.
interface param_updown_counter_if #(
  parameter int unsigned WIDTH = 4
);

  logic             en;
  logic             up;
  logic             sat;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             clr;
  logic [WIDTH-1:0] counter;
  logic             tc;
  logic             ovf;
  logic             unf;

  modport master (
    output en, up, sat, load, load_value, clr,
    input  counter, tc, ovf, unf
  );

  modport slave (
    input  en, up, sat, load, load_value, clr,
    output counter, tc, ovf, unf
  );

endinterface

// File: rtl/param_updown_counter_prescale_tick.sv
// Enable-gated prescaler: emits one tick every PRESCALE enabled cycles.
// restart discards any partial count; PRESCALE=1 degenerates to tick = en.
module prescale_tick #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic restart,
  output logic tick
);

  if (PRESCALE == 1) begin : g_bypass
    logic unused_ok;
    assign unused_ok = ^{clk, reset, restart};
    assign tick      = en;
  end else begin : g_count
    localparam int unsigned     PW   = $clog2(PRESCALE);
    localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
      cnt_d = cnt_q;
      if (restart) begin
        cnt_d = '0;
      end else if (en) begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
      end
    end

    // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign tick = en && (cnt_q == LAST);
  end

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with wrap/saturate boundaries, load/clear,
// prescaled stepping, a registered terminal-count pulse and sticky ovf/unf flags.
module param_updown_counter
  import param_updown_counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_VALUE = 15,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  param_updown_counter_if.slave    bus
);

  if (WIDTH < 1 || WIDTH > CNT_MAX_W) begin : g_bad_width
    $error("param_updown_counter: WIDTH must be in 1..32");
  end
  if (64'(MAX_VALUE) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
    $error("param_updown_counter: MAX_VALUE does not fit in WIDTH bits");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("param_updown_counter: PRESCALE must be at least 1");
  end

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VALUE);

  logic [WIDTH-1:0] counter_q, counter_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] load_clamped;
  logic             tick;

  prescale_tick #(
    .PRESCALE (PRESCALE)
  ) u_prescale (
    .clk     (clk),
    .reset   (reset),
    .en      (bus.en),
    .restart (bus.clr | bus.load),
    .tick    (tick)
  );

  assign load_clamped = WIDTH'(clamp_load(cnt_word_t'(bus.load_value), cnt_word_t'(MAX_VALUE)));

  // Priority is clr > load > step; tc defaults low so it only pulses after a boundary step.
  always_comb begin
    counter_d = counter_q;
    tc_d      = 1'b0;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    if (bus.clr) begin
      counter_d = '0;
      ovf_d     = 1'b0;
      unf_d     = 1'b0;
    end else if (bus.load) begin
      counter_d = load_clamped;
    end else if (tick) begin
      if (bus.up == CNT_DIR_UP) begin
        if (counter_q == MAX_W) begin
          counter_d = (bus.sat == CNT_MODE_SAT) ? MAX_W : '0;
          ovf_d     = 1'b1;
          tc_d      = 1'b1;
        end else begin
          counter_d = counter_q + WIDTH'(1);
        end
      end else begin
        if (counter_q == '0) begin
          counter_d = (bus.sat == CNT_MODE_SAT) ? '0 : MAX_W;
          unf_d     = 1'b1;
          tc_d      = 1'b1;
        end else begin
          counter_d = counter_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter_q <= '0;
      tc_q      <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      counter_q <= counter_d;
      tc_q      <= tc_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign bus.counter = counter_q;
  assign bus.tc      = tc_q;
  assign bus.ovf     = ovf_q;
  assign bus.unf     = unf_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter: a PRESCALE=1 instance (a) and a PRESCALE=3 instance (b),
// both WIDTH=4, MAX_VALUE=9. Observations are packed as {counter, tc, ovf, unf}.
module tb_param_updown_counter;

  logic clk;
  logic reset_a;
  logic reset_b;

  int total;
  int bad;

  param_updown_counter_if #(.WIDTH(4)) a_if ();
  param_updown_counter_if #(.WIDTH(4)) b_if ();

  param_updown_counter #(
    .WIDTH     (4),
    .MAX_VALUE (9),
    .PRESCALE  (1)
  ) dut_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (a_if)
  );

  param_updown_counter #(
    .WIDTH     (4),
    .MAX_VALUE (9),
    .PRESCALE  (3)
  ) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    reset_a = 1'b1;
    reset_b = 1'b1;
    a_if.en = 0; a_if.up = 0; a_if.sat = 0; a_if.load = 0; a_if.clr = 0; a_if.load_value = '0;
    b_if.en = 0; b_if.up = 0; b_if.sat = 0; b_if.load = 0; b_if.clr = 0; b_if.load_value = '0;
    #20;
    obs = {a_if.counter, a_if.tc, a_if.ovf, a_if.unf};
    total++;
    if (obs !== 7'b0000_000) begin
      bad++;
      $display("FAIL reset_a: got cnt=%0d tc=%0b ovf=%0b unf=%0b want all 0", obs[6:3], obs[2], obs[1], obs[0]);
    end
    obs = {b_if.counter, b_if.tc, b_if.ovf, b_if.unf};
    total++;
    if (obs !== 7'b0000_000) begin
      bad++;
      $display("FAIL reset_b: got cnt=%0d tc=%0b ovf=%0b unf=%0b want all 0", obs[6:3], obs[2], obs[1], obs[0]);
    end
    reset_a = 1'b0;
    reset_b = 1'b0;
  endtask

  task automatic test_wrap_up();
    logic [6:0] obs;
    logic [6:0] exp_v;
    a_if.en = 1; a_if.up = 1; a_if.sat = 0;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      exp_v = {4'(i % 10), (i == 10), (i == 10), 1'b0};
      obs   = {a_if.counter, a_if.tc, a_if.ovf, a_if.unf};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL wrap_up step %0d: got cnt=%0d tc=%0b ovf=%0b unf=%0b want cnt=%0d tc=%0b ovf=%0b unf=%0b",
                 i, obs[6:3], obs[2], obs[1], obs[0], exp_v[6:3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
    a_if.en = 0;
    cycle();
    obs = {a_if.counter, a_if.tc, a_if.ovf, a_if.unf};
    total++;
    if (obs !== {4'd0, 1'b0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL wrap_hold: got cnt=%0d tc=%0b ovf=%0b unf=%0b want cnt=0 tc=0 ovf=1 unf=0",
               obs[6:3], obs[2], obs[1], obs[0]);
    end
  endtask

  task automatic test_sat_down();
    logic [6:0] obs;
    logic [6:0] exp_v [5];
    exp_v = '{{4'd0, 3'b111}, {4'd0, 3'b111}, {4'd0, 3'b111}, {4'd1, 3'b011}, {4'd2, 3'b011}};
    a_if.en = 1; a_if.up = 0; a_if.sat = 1;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) a_if.up = 1;
      cycle();
      obs = {a_if.counter, a_if.tc, a_if.ovf, a_if.unf};
      total++;
      if (obs !== exp_v[i]) begin
        bad++;
        $display("FAIL sat_down step %0d: got cnt=%0d tc=%0b ovf=%0b unf=%0b want cnt=%0d tc=%0b ovf=%0b unf=%0b",
                 i, obs[6:3], obs[2], obs[1], obs[0], exp_v[i][6:3], exp_v[i][2], exp_v[i][1], exp_v[i][0]);
      end
    end
    a_if.en = 0;
  endtask

  task automatic test_load();
    logic [6:0] obs;
    logic [6:0] exp_v [3];
    logic [3:0] lv    [3];
    logic       ld    [3];
    exp_v = '{{4'd7, 3'b011}, {4'd9, 3'b011}, {4'd0, 3'b111}};
    lv    = '{4'd7, 4'd12, 4'd0};
    ld    = '{1'b1, 1'b1, 1'b0};
    a_if.en = 1; a_if.up = 1; a_if.sat = 0;
    for (int i = 0; i < 3; i++) begin
      a_if.load       = ld[i];
      a_if.load_value = lv[i];
      cycle();
      obs = {a_if.counter, a_if.tc, a_if.ovf, a_if.unf};
      total++;
      if (obs !== exp_v[i]) begin
        bad++;
        $display("FAIL load step %0d: got cnt=%0d tc=%0b ovf=%0b unf=%0b want cnt=%0d tc=%0b ovf=%0b unf=%0b",
                 i, obs[6:3], obs[2], obs[1], obs[0], exp_v[i][6:3], exp_v[i][2], exp_v[i][1], exp_v[i][0]);
      end
    end
    a_if.load = 0;
    a_if.en   = 0;
  endtask

  task automatic test_clr_load();
    logic [6:0] obs;
    a_if.clr = 1; a_if.load = 1; a_if.load_value = 4'd5; a_if.en = 1; a_if.up = 1;
    cycle();
    obs = {a_if.counter, a_if.tc, a_if.ovf, a_if.unf};
    total++;
    if (obs !== 7'b0000_000) begin
      bad++;
      $display("FAIL clr_over_load: got cnt=%0d tc=%0b ovf=%0b unf=%0b want all 0", obs[6:3], obs[2], obs[1], obs[0]);
    end
    a_if.clr = 0; a_if.load = 0; a_if.up = 0; a_if.sat = 0; a_if.en = 1;
    cycle();
    obs = {a_if.counter, a_if.tc, a_if.ovf, a_if.unf};
    total++;
    if (obs !== {4'd9, 1'b1, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL wrap_down: got cnt=%0d tc=%0b ovf=%0b unf=%0b want cnt=9 tc=1 ovf=0 unf=1",
               obs[6:3], obs[2], obs[1], obs[0]);
    end
    a_if.en = 0;
  endtask

  task automatic test_prescale();
    logic [3:0] obs;
    logic       tc_obs;
    int         exp_cnt [17];
    exp_cnt = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 3, 3, 3, 4, 4, 4, 5};
    b_if.up = 1; b_if.sat = 0;
    for (int k = 1; k <= 17; k++) begin
      b_if.en = !(k == 8 || k == 9);
      cycle();
      obs    = b_if.counter;
      tc_obs = b_if.tc;
      total++;
      if (obs !== 4'(exp_cnt[k-1]) || tc_obs !== 1'b0) begin
        bad++;
        $display("FAIL prescale edge %0d: got cnt=%0d tc=%0b want cnt=%0d tc=0", k, obs, tc_obs, exp_cnt[k-1]);
      end
    end
    b_if.en = 1;
  endtask

  task automatic test_async_reset();
    logic [6:0] obs;
    logic [3:0] cnt_obs;
    int         exp_after [3];
    exp_after = '{0, 0, 1};
    cycle();
    #2;
    reset_b = 1'b1;
    #1;
    obs = {b_if.counter, b_if.tc, b_if.ovf, b_if.unf};
    total++;
    if (obs !== 7'b0000_000) begin
      bad++;
      $display("FAIL async_reset: got cnt=%0d tc=%0b ovf=%0b unf=%0b want all 0", obs[6:3], obs[2], obs[1], obs[0]);
    end
    #2;
    reset_b = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      cnt_obs = b_if.counter;
      total++;
      if (cnt_obs !== 4'(exp_after[k])) begin
        bad++;
        $display("FAIL post_reset edge %0d: got cnt=%0d want cnt=%0d", k + 1, cnt_obs, exp_after[k]);
      end
    end
    b_if.en = 0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_load();
    test_clr_load();
    test_prescale();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
